// File: rtl/vedic_div_pkg.sv
// Shared types and defaults for the restoring divider in the PE arithmetic cluster.
package vedic_div_pkg;

    localparam int DIV_DW = 8;
    localparam int DIV_VW = 4;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } div_state_t;

    function automatic int cnt_width(input int dw);
        return (dw > 1) ? $clog2(dw) : 1;
    endfunction

endpackage

// File: rtl/div_restore_step.sv
// One combinational restoring-division iteration: shift in the next dividend bit,
// then subtract the divisor if it fits.
module div_restore_step #(
    parameter int VW = 4
) (
    input  logic [VW:0]   rem,
    input  logic          quo_msb,
    input  logic [VW-1:0] divisor,
    output logic [VW:0]   rem_next,
    output logic          quo_bit
);

    logic [VW:0] shifted;
    logic [VW:0] diff;
    logic        rem_msb_unused;

    // The partial remainder is always below the divisor, so its top bit is zero
    // before the shift and can be dropped without loss.
    assign rem_msb_unused = rem[VW];
    assign shifted        = {rem[VW-1:0], quo_msb};
    assign diff           = shifted - {1'b0, divisor};
    assign quo_bit        = (shifted >= {1'b0, divisor});
    assign rem_next       = quo_bit ? diff : shifted;

endmodule

// File: rtl/vedic_div_8_by_4.sv
// Sequential restoring divider, one quotient bit per clock, with valid/ready
// handshakes on both sides.
module vedic_div_8_by_4
    import vedic_div_pkg::*;
#(
    parameter int DW = DIV_DW,
    parameter int VW = DIV_VW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int            CW   = cnt_width(DW);
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    div_state_t    state, state_d;
    logic [VW:0]   rem_q, rem_next;
    logic [DW-1:0] quo_q;
    logic [VW-1:0] dvs_q;
    logic [CW-1:0] cnt;
    logic          quo_bit;
    logic          accept;
    logic          last_step;

    div_restore_step #(.VW(VW)) u_step (
        .rem      (rem_q),
        .quo_msb  (quo_q[DW-1]),
        .divisor  (dvs_q),
        .rem_next (rem_next),
        .quo_bit  (quo_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        last_step = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid) begin
                    state_d = (divisor == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                last_step = (cnt == LAST);
                if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
            cnt   <= '0;
            // A zero divisor short-circuits straight to a saturated result.
            if (divisor == '0) begin
                quotient    <= '1;
                remainder   <= '0;
                div_by_zero <= 1'b1;
            end
        end else if (state == BUSY) begin
            rem_q <= rem_next;
            quo_q <= {quo_q[DW-2:0], quo_bit};
            cnt   <= cnt + 1'b1;
            if (last_step) begin
                quotient    <= {quo_q[DW-2:0], quo_bit};
                remainder   <= rem_next[VW-1:0];
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule
